// File: rtl/cra_sequencer.sv
// KL10 microcode address sequencer: next-CRADR selection, return stack,
// page-fail trap entry and diagnostic address load.
module cra_sequencer #(
    parameter int          STACK_DEPTH = 16,
    parameter logic [11:0] TRAP_VEC    = 12'o0007
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cyc_en,
    input  logic [11:0]                   J,
    input  logic                          CALL,
    input  logic                          skip_true,
    input  logic                          disp_or,
    input  logic [3:0]                    disp_bits,
    input  logic                          disp_ret,
    input  logic                          pf_trap,
    input  logic                          diag_ld,
    input  logic [11:0]                   diag_adr,
    output logic [11:0]                   CRADR,
    output logic [$clog2(STACK_DEPTH):0]  stk_depth,
    output logic                          stk_ovf,
    output logic                          stk_unf
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(STACK_DEPTH);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);

    logic [11:0]   stk [STACK_DEPTH];
    logic [AW-1:0] top_idx;
    logic [11:0]   top;
    logic          empty;
    logic          full;
    logic          adv;

    logic [11:0]   base;
    logic [11:0]   next_adr;
    logic [AW:0]   next_depth;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic          set_ovf;
    logic          set_unf;

    assign empty   = (stk_depth == '0);
    assign full    = (stk_depth == FULL);
    assign top_idx = AW'(stk_depth - ONE);
    assign top     = empty ? 12'o0000 : stk[top_idx];
    assign adv     = cyc_en && !diag_ld && !reset;

    always_comb begin
        base       = J;
        next_adr   = CRADR;
        next_depth = stk_depth;
        wr_en      = 1'b0;
        wr_idx     = stk_depth[AW-1:0];
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        if (pf_trap) begin
            next_adr = TRAP_VEC;
            if (full) begin
                set_ovf = 1'b1;
            end else begin
                wr_en      = 1'b1;
                next_depth = stk_depth + ONE;
            end
        end else begin
            if (disp_ret) base = base | top;
            if (disp_or)  base = base | {8'b0, disp_bits};
            next_adr = base | {11'b0, skip_true};
            unique case ({CALL, disp_ret})
                2'b11: begin
                    // Return-and-call: the caller replaces the popped slot.
                    wr_en = 1'b1;
                    if (empty) begin
                        set_unf    = 1'b1;
                        next_depth = ONE;
                    end else begin
                        wr_idx = top_idx;
                    end
                end
                2'b10: begin
                    if (full) begin
                        set_ovf = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        next_depth = stk_depth + ONE;
                    end
                end
                2'b01: begin
                    if (empty) set_unf = 1'b1;
                    else       next_depth = stk_depth - ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            CRADR     <= '0;
            stk_depth <= '0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
        end else if (diag_ld) begin
            CRADR   <= diag_adr;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (cyc_en) begin
            CRADR     <= next_adr;
            stk_depth <= next_depth;
            stk_ovf   <= stk_ovf | set_ovf;
            stk_unf   <= stk_unf | set_unf;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && wr_en) stk[wr_idx] <= CRADR;
    end

endmodule

// File: tb/tb_cra_sequencer.sv
// Directed scoreboard bench for cra_sequencer: a queue-based reference
// model predicts each cycle's outputs, which are checked after the edge.
module tb_cra_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cyc_en = 1'b0;
    logic [11:0] J = '0;
    logic        CALL = 1'b0;
    logic        skip_true = 1'b0;
    logic        disp_or = 1'b0;
    logic [3:0]  disp_bits = '0;
    logic        disp_ret = 1'b0;
    logic        pf_trap = 1'b0;
    logic        diag_ld = 1'b0;
    logic [11:0] diag_adr = '0;
    logic [11:0] CRADR;
    logic [4:0]  stk_depth;
    logic        stk_ovf;
    logic        stk_unf;

    int tests = 0;
    int fails = 0;

    // Expected {CRADR, depth, ovf, unf} per stepped cycle.
    logic [18:0] sb [$];

    logic [11:0] m_adr = '0;
    logic [11:0] m_stk [$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    cra_sequencer #(.STACK_DEPTH(16), .TRAP_VEC(12'o0007)) dut (
        .clk(clk), .reset(reset), .cyc_en(cyc_en), .J(J), .CALL(CALL),
        .skip_true(skip_true), .disp_or(disp_or), .disp_bits(disp_bits),
        .disp_ret(disp_ret), .pf_trap(pf_trap), .diag_ld(diag_ld),
        .diag_adr(diag_adr), .CRADR(CRADR), .stk_depth(stk_depth),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    task automatic model();
        logic [11:0] b;
        logic [11:0] old;
        old = m_adr;
        if (reset) begin
            m_adr = '0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (diag_ld) begin
            m_adr = diag_adr;
            m_ovf = 0;
            m_unf = 0;
        end else if (cyc_en) begin
            if (pf_trap) begin
                if (m_stk.size() < 16) m_stk.push_back(old);
                else m_ovf = 1;
                m_adr = 12'o0007;
            end else begin
                b = J;
                if (disp_ret && CALL && m_stk.size() > 0) begin
                    b = b | m_stk[$];
                    m_stk[$] = old;
                end else begin
                    if (disp_ret) begin
                        if (m_stk.size() > 0) b = b | m_stk.pop_back();
                        else m_unf = 1;
                    end
                    if (CALL) begin
                        if (m_stk.size() < 16) m_stk.push_back(old);
                        else m_ovf = 1;
                    end
                end
                if (disp_or) b = b | {8'b0, disp_bits};
                m_adr = b | {11'b0, skip_true};
            end
        end
    endtask

    task automatic step(input string tag);
        logic [18:0] exp;
        logic [18:0] obs;
        model();
        sb.push_back({m_adr, 5'(m_stk.size()), m_ovf, m_unf});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        obs = {CRADR, stk_depth, stk_ovf, stk_unf};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got adr=%o dep=%0d ovf=%b unf=%b exp adr=%o dep=%0d ovf=%b unf=%b",
                   tag, obs[18:7], obs[6:2], obs[1], obs[0],
                   exp[18:7], exp[6:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %o exp %o", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 0; cyc_en = 0; J = '0; CALL = 0; skip_true = 0;
        disp_or = 0; disp_bits = '0; disp_ret = 0; pf_trap = 0;
        diag_ld = 0; diag_adr = '0;
    endtask

    initial begin
        idle();
        #2;
        reset = 1; cyc_en = 1;
        step("reset");
        chk("reset_adr", CRADR, 12'o0000);

        idle(); cyc_en = 1; J = 12'o0100;
        step("j0100");
        chk("j0100_adr", CRADR, 12'o0100);
        skip_true = 1;
        step("skip");
        chk("skip_adr", CRADR, 12'o0101);

        idle(); diag_ld = 1; diag_adr = 12'o0200;
        step("diag0200");
        idle(); cyc_en = 1; CALL = 1; J = 12'o0300;
        step("call");
        chk("call_adr", CRADR, 12'o0300);
        idle(); cyc_en = 1; disp_ret = 1; J = 12'o0001;
        step("ret");
        chk("ret_adr", CRADR, 12'o0201);

        idle(); cyc_en = 1; J = 12'o0400; disp_or = 1;
        disp_bits = 4'b1010; skip_true = 1;
        step("disp");
        chk("disp_adr", CRADR, 12'o0413);

        for (int i = 0; i < 17; i++) begin
            idle(); cyc_en = 1; CALL = 1; J = 12'(12'o1000 + 2 * i);
            step("push");
        end
        chk("ovf_depth", 12'(stk_depth), 12'd16);
        for (int i = 0; i < 16; i++) begin
            idle(); cyc_en = 1; disp_ret = 1; J = 12'o0001;
            step("unwind");
        end
        idle(); cyc_en = 1; disp_ret = 1; J = 12'o0040;
        step("underflow");
        chk("unf_adr", CRADR, 12'o0040);

        idle(); diag_ld = 1; diag_adr = 12'o0555;
        step("diag0555");
        idle(); cyc_en = 1; pf_trap = 1; CALL = 1; J = 12'o0123;
        step("trap");
        chk("trap_adr", CRADR, 12'o0007);
        idle(); pf_trap = 1; CALL = 1; J = 12'o0321;
        step("trap_hold");
        idle(); cyc_en = 1; disp_ret = 1;
        step("trap_top");
        chk("trap_top_adr", CRADR, 12'o0555);

        idle(); cyc_en = 1; CALL = 1; J = 12'o0600;
        step("pre_swap");
        idle(); cyc_en = 1; CALL = 1; disp_ret = 1; J = 12'o0002;
        step("swap");
        idle(); cyc_en = 1; disp_ret = 1; J = 12'o0000;
        step("swap_ret");
        chk("swap_ret_adr", CRADR, 12'o0600);

        idle(); cyc_en = 1; disp_ret = 1; J = 12'o0700;
        step("set_unf");
        idle(); diag_ld = 1; diag_adr = 12'o7777;
        step("diag7777");
        chk("diag_adr", CRADR, 12'o7777);

        idle(); cyc_en = 1; CALL = 1; J = 12'o0050;
        step("call2");
        idle(); cyc_en = 1; CALL = 1; reset = 1; J = 12'o0060;
        step("reset_call");
        chk("reset_call_adr", CRADR, 12'o0000);

        for (int i = 0; i < 60; i++) begin
            idle();
            cyc_en    = 1'($urandom_range(0, 3) != 0);
            J         = 12'($urandom);
            CALL      = 1'($urandom_range(0, 2) == 0);
            disp_ret  = 1'($urandom_range(0, 2) == 0);
            skip_true = 1'($urandom);
            disp_or   = 1'($urandom);
            disp_bits = 4'($urandom);
            pf_trap   = 1'($urandom_range(0, 9) == 0);
            diag_ld   = 1'($urandom_range(0, 14) == 0);
            diag_adr  = 12'($urandom);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
